// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the multiply/divide datapath
package mdu_pkg;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_MULU = 2'b10, OP_DIVU = 2'b11} op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;
  localparam int MAX_W = 128;
  localparam logic [MAX_W-1:0] DIV0_QUOT = '1;
endpackage

// File: rtl/mdu_regfile_datapath_if.sv
// mdu_regfile_datapath_if: register-file bus plus multiply/divide issue handshake
interface mdu_regfile_datapath_if #(
  parameter int WIDTH = 32,
  parameter int AW = 4
);
  import mdu_pkg::*;
  logic wr_en, ba_mode, hi_wr, lo_wr, op_valid, op_ready, done, div_by_zero;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b, op_src_a, op_src_b;
  logic [WIDTH-1:0] wr_data, rd_data_a, rd_data_b, hi, lo;
  op_t op_code;
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, ba_mode, hi_wr, lo_wr,
           op_valid, op_code, op_src_a, op_src_b,
    input  rd_data_a, rd_data_b, op_ready, hi, lo, done, div_by_zero
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, ba_mode, hi_wr, lo_wr,
           op_valid, op_code, op_src_a, op_src_b,
    output rd_data_a, rd_data_b, op_ready, hi, lo, done, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiplier / restoring divider on magnitudes with sign fix-up
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] x, y, m, a_mag, b_mag, diff;
  logic [WIDTH:0] sum, t;
  logic [2*WIDTH-1:0] prod;
  logic sgn, ge, div_q, neg_hi, neg_lo;
  assign sgn = !op[1];
  assign a_mag = sgn && a[WIDTH-1] ? -a : a;
  assign b_mag = sgn && b[WIDTH-1] ? -b : b;
  assign sum = {1'b0, x} + (y[0] ? {1'b0, m} : '0);
  assign t = {x, y[WIDTH-1]};
  assign ge = t >= {1'b0, m};
  assign diff = t[WIDTH-1:0] - m;
  assign prod = {x, y};
  assign last = cnt == CW'(1);
  assign {res_hi, res_lo} = div_q ? {neg_hi ? -x : x, neg_lo ? -y : y} : (neg_lo ? -prod : prod);
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      x <= '0;
      y <= '0;
      m <= '0;
      div_q <= 1'b0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      x <= '0;
      y <= op[0] ? a_mag : b_mag;
      m <= op[0] ? b_mag : a_mag;
      div_q <= op[0];
      neg_hi <= sgn && a[WIDTH-1];
      neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      x <= div_q ? (ge ? diff : t[WIDTH-1:0]) : sum[WIDTH:1];
      y <= div_q ? {y[WIDTH-2:0], ge} : {sum[0], y[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mdu_regfile_datapath.sv
// mdu_regfile_datapath: general register file, HI/LO and issue FSM around the mdu_iter engine
module mdu_regfile_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW = $clog2(NREGS)
) (
  input logic clk,
  input logic clr,
  mdu_regfile_datapath_if.slave bus
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_val, b_val, res_hi, res_lo, hi_q, lo_q;
  state_t state, state_n;
  logic accept, div0, last, dbz_q;
  assign a_val = regs[bus.op_src_a];
  assign b_val = regs[bus.op_src_b];
  assign accept = bus.op_valid && state == ST_IDLE;
  assign div0 = bus.op_code[0] && b_val == '0;
  assign bus.rd_data_a = bus.ba_mode && bus.rd_addr_a == AW'(0) ? '0 : regs[bus.rd_addr_a];
  assign bus.rd_data_b = regs[bus.rd_addr_b];
  assign bus.op_ready = state == ST_IDLE;
  assign bus.done = state == ST_DONE;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.div_by_zero = dbz_q;
  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk),
    .clr(clr),
    .start(accept && !div0),
    .op(bus.op_code),
    .a(a_val),
    .b(b_val),
    .last(last),
    .res_hi(res_hi),
    .res_lo(res_lo)
  );
  always_comb begin
    state_n = state;
    state_n = state == ST_IDLE ? (accept ? (div0 ? ST_DONE : ST_RUN) : ST_IDLE) :
              state == ST_RUN  ? (last ? ST_FIX : ST_RUN) :
              state == ST_FIX  ? ST_DONE : ST_IDLE;
  end
  always_ff @(posedge clk)
    if (clr) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
      hi_q <= '0;
      lo_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) dbz_q <= div0;
      if (state == ST_FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (accept && div0) begin
        hi_q <= a_val;
        lo_q <= DIV0_QUOT[WIDTH-1:0];
      end else if (state == ST_IDLE) begin
        if (bus.hi_wr) hi_q <= bus.wr_data;
        if (bus.lo_wr) lo_q <= bus.wr_data;
      end
    end
  end
endmodule

// File: tb/tb_mdu_regfile_datapath.sv
// tb_mdu_regfile_datapath: randomized self-checking bench against an arithmetic reference model
module tb_mdu_regfile_datapath;
  import mdu_pkg::*;
  localparam int W = 32;
  localparam int N = 16;
  localparam int A = 4;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] mregs [N];
  logic [W-1:0] e_hi, e_lo;
  logic e_dbz;
  always #5 clk = ~clk;
  mdu_regfile_datapath_if #(.WIDTH(W), .AW(A)) bus();
  mdu_regfile_datapath #(.WIDTH(W), .NREGS(N)) dut (.clk(clk), .clr(clr), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_reg(input int r, input logic [W-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = A'(r);
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    mregs[r] = d;
  endtask
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
    longint sa, sb;
    logic [2*W-1:0] p;
    int si, di;
    ed = 1'b0;
    if (!op[0]) begin
      if (op[1]) p = {32'b0, a} * {32'b0, b};
      else begin
        si = $signed(a);
        di = $signed(b);
        sa = si;
        sb = di;
        p = sa * sb;
      end
      {eh, el} = p;
    end else if (b == 0) begin
      eh = a;
      el = '1;
      ed = 1'b1;
    end else if (op[1]) begin
      el = a / b;
      eh = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      el = a;
      eh = '0;
    end else begin
      si = $signed(a);
      di = $signed(b);
      el = si / di;
      eh = si % di;
    end
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction
  task automatic issue(input logic [1:0] op, input int sa, input int sb);
    ref_op(op, mregs[sa], mregs[sb], e_hi, e_lo, e_dbz);
    bus.op_valid = 1'b1;
    bus.op_code = op_t'(op);
    bus.op_src_a = A'(sa);
    bus.op_src_b = A'(sb);
  endtask
  task automatic finish_op(input string tag);
    int lat = 0;
    while (!bus.done && lat < 100) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, e_dbz ? 0 : W + 1);
    chk({tag, "_hi"}, bus.hi, e_hi);
    chk({tag, "_lo"}, bus.lo, e_lo);
    chk({tag, "_dbz"}, bus.div_by_zero, e_dbz);
    step();
    chk({tag, "_done_drop"}, bus.done, 0);
    chk({tag, "_ready"}, bus.op_ready, 1);
  endtask
  task automatic run_op(input string tag, input logic [1:0] op, input int sa, input int sb);
    chk({tag, "_ready_pre"}, bus.op_ready, 1);
    issue(op, sa, sb);
    step();
    bus.op_valid = 1'b0;
    finish_op(tag);
  endtask
  initial begin
    int dones;
    bit busy_ok;
    {bus.wr_en, bus.ba_mode, bus.hi_wr, bus.lo_wr, bus.op_valid} = '0;
    {bus.wr_addr, bus.rd_addr_a, bus.rd_addr_b, bus.op_src_a, bus.op_src_b} = '0;
    bus.wr_data = '0;
    bus.op_code = OP_MUL;
    for (int i = 0; i < N; i++) mregs[i] = '0;
    step();
    step();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) wr_reg($urandom_range(0, N - 1), $urandom());
    bus.lo_wr = 1'b1;
    bus.wr_data = 32'hCAFE_0001;
    step();
    bus.lo_wr = 1'b0;
    chk("lo_bus_wr", bus.lo, 32'hCAFE_0001);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < N; i++) mregs[i] = '0;
    for (int i = 0; i < N; i++) begin
      bus.rd_addr_a = A'(i);
      bus.rd_addr_b = A'(N - 1 - i);
      #1;
      chk("rst_rd_a", bus.rd_data_a, 0);
      chk("rst_rd_b", bus.rd_data_b, 0);
    end
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_ready", bus.op_ready, 1);
    bus.rd_addr_a = 4'd5;
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'd5;
    bus.wr_data = 32'h1234;
    #1;
    chk("no_bypass", bus.rd_data_a, 0);
    step();
    bus.wr_en = 1'b0;
    mregs[5] = 32'h1234;
    chk("rd_after_wr", bus.rd_data_a, 32'h1234);
    wr_reg(0, 7);
    bus.rd_addr_a = 4'd0;
    bus.rd_addr_b = 4'd0;
    bus.ba_mode = 1'b1;
    #1;
    chk("ba_rd_a", bus.rd_data_a, 0);
    chk("ba_rd_b", bus.rd_data_b, 7);
    bus.ba_mode = 1'b0;
    #1;
    chk("noba_rd_a", bus.rd_data_a, 7);
    wr_reg(1, -6);
    wr_reg(2, 7);
    run_op("mul_s", 2'b00, 1, 2);
    chk("mul_s_hi_k", e_hi, 32'hFFFF_FFFF);
    wr_reg(3, 32'hFFFF_FFFF);
    wr_reg(4, 2);
    run_op("mulu", 2'b10, 3, 4);
    wr_reg(6, -17);
    wr_reg(7, 5);
    run_op("div_s", 2'b01, 6, 7);
    wr_reg(8, 32'h8000_0000);
    wr_reg(9, 32'hFFFF_FFFF);
    run_op("div_min", 2'b01, 8, 9);
    wr_reg(10, 42);
    wr_reg(11, 0);
    bus.ba_mode = 1'b1;
    run_op("div0", 2'b01, 10, 11);
    bus.ba_mode = 1'b0;
    chk("dbz_sticky", bus.div_by_zero, 1);
    issue(2'b00, 1, 2);
    step();
    bus.op_valid = 1'b0;
    chk("dbz_clr", bus.div_by_zero, 0);
    finish_op("mul_after_div0");
    wr_reg(12, 100);
    wr_reg(13, 3);
    issue(2'b11, 12, 13);
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'd12;
    bus.wr_data = 555;
    bus.rd_addr_b = 4'd12;
    step();
    bus.wr_en = 1'b0;
    mregs[12] = 555;
    busy_ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (bus.op_ready) busy_ok = 1'b0;
      if (i == 3) chk("busy_rd", bus.rd_data_b, 555);
      bus.hi_wr = i == 5;
      bus.wr_data = 32'hDEAD_0000;
      step();
    end
    bus.hi_wr = 1'b0;
    chk("busy_no_ready", busy_ok, 1);
    step();
    chk("hold_done", bus.done, 1);
    chk("hold_hi", bus.hi, e_hi);
    chk("hold_lo", bus.lo, e_lo);
    bus.op_valid = 1'b0;
    bus.hi_wr = 1'b1;
    bus.wr_data = 32'hDEAD_BEEF;
    step();
    bus.hi_wr = 1'b0;
    chk("done_hiwr_drop", bus.hi, e_hi);
    chk("hold_ready", bus.op_ready, 1);
    step();
    chk("no_reaccept", bus.op_ready, 1);
    wr_reg(14, 1000);
    wr_reg(15, -7);
    issue(2'b01, 14, 15);
    bus.hi_wr = 1'b1;
    bus.wr_data = 32'h5A5A;
    step();
    bus.hi_wr = 1'b0;
    bus.op_valid = 1'b0;
    chk("acc_hiwr_hi", bus.hi, 32'h5A5A);
    chk("acc_busy", bus.op_ready, 0);
    finish_op("acc_hiwr");
    issue(2'b00, 1, 2);
    step();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < N; i++) mregs[i] = '0;
    chk("abort_done", bus.done, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_ready", bus.op_ready, 1);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      dones += int'(bus.done);
      step();
    end
    chk("abort_no_done", dones, 0);
    wr_reg(1, 123);
    wr_reg(2, -9);
    run_op("post_abort", 2'b00, 1, 2);
    for (int k = 0; k < 30; k++) begin
      int ra, rb, rd;
      logic [1:0] op;
      ra = $urandom_range(0, N - 1);
      rb = $urandom_range(0, N - 1);
      wr_reg(ra, pick());
      wr_reg(rb, pick());
      rd = $urandom_range(0, N - 1);
      bus.ba_mode = 1'($urandom_range(0, 1));
      bus.rd_addr_a = A'(rd);
      bus.rd_addr_b = A'(ra);
      #1;
      chk("rnd_rd_a", bus.rd_data_a, bus.ba_mode && rd == 0 ? 0 : mregs[rd]);
      chk("rnd_rd_b", bus.rd_data_b, mregs[ra]);
      op = 2'($urandom_range(0, 3));
      run_op("rnd", op, $urandom_range(0, N - 1), rb);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
